// File: rtl/h264_pkg.sv
// Shared definitions for the H.264 macroblock scheduling path:
// counter widths, default frame geometry, scheduler states and the availability rule.
package h264_pkg;

  localparam int MBNUM_W  = 13;
  localparam int MBXY_W   = 7;
  localparam int MB_W_DEF = 120;
  localparam int MB_H_DEF = 68;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2,
    FRAME_END = 2'd3
  } sched_state_e;

  typedef struct packed {
    logic left;
    logic top;
    logic topleft;
    logic topright;
  } mb_avail_t;

  // Neighbour availability for intra prediction; x_max is the last column of the frame.
  function automatic mb_avail_t calc_avail(input logic [MBXY_W-1:0] x,
                                           input logic [MBXY_W-1:0] y,
                                           input logic [MBXY_W-1:0] x_max);
    mb_avail_t a;
    a.left     = (x != {MBXY_W{1'b0}});
    a.top      = (y != {MBXY_W{1'b0}});
    a.topleft  = a.left & a.top;
    a.topright = a.top & (x != x_max);
    return a;
  endfunction

endpackage

// File: rtl/mb_counter2d.sv
// Raster macroblock position counter: column, row and linear index with
// wrap at the frame edge, plus a flag marking the last macroblock of the frame.
module mb_counter2d
  import h264_pkg::*;
#(
  parameter int MB_W = MB_W_DEF,
  parameter int MB_H = MB_H_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               i_clear,
  input  logic               i_advance,
  output logic [MBXY_W-1:0]  o_mb_x,
  output logic [MBXY_W-1:0]  o_mb_y,
  output logic [MBNUM_W-1:0] o_mbnumber,
  output logic [MBXY_W-1:0]  o_nxt_x,
  output logic [MBXY_W-1:0]  o_nxt_y,
  output logic               o_last
);

  localparam logic [MBXY_W-1:0]  X_MAX   = MBXY_W'(MB_W - 1);
  localparam logic [MBXY_W-1:0]  Y_MAX   = MBXY_W'(MB_H - 1);
  localparam logic [MBNUM_W-1:0] IDX_MAX = MBNUM_W'(MB_W * MB_H - 1);

  logic [MBXY_W-1:0]  r_x;
  logic [MBXY_W-1:0]  r_y;
  logic [MBNUM_W-1:0] r_idx;
  logic [MBXY_W-1:0]  w_nxt_x;
  logic [MBXY_W-1:0]  w_nxt_y;
  logic [MBNUM_W-1:0] w_nxt_idx;

  // Next position: clear has priority over advance; row wraps only as a safe fallback.
  always_comb begin
    w_nxt_x   = r_x;
    w_nxt_y   = r_y;
    w_nxt_idx = r_idx;
    if (i_clear) begin
      w_nxt_x   = {MBXY_W{1'b0}};
      w_nxt_y   = {MBXY_W{1'b0}};
      w_nxt_idx = {MBNUM_W{1'b0}};
    end else if (i_advance) begin
      w_nxt_idx = r_idx + MBNUM_W'(1);
      if (r_x == X_MAX) begin
        w_nxt_x = {MBXY_W{1'b0}};
        if (r_y == Y_MAX) begin
          w_nxt_y = {MBXY_W{1'b0}};
        end else begin
          w_nxt_y = r_y + MBXY_W'(1);
        end
      end else begin
        w_nxt_x = r_x + MBXY_W'(1);
        w_nxt_y = r_y;
      end
    end else begin
      w_nxt_x   = r_x;
      w_nxt_y   = r_y;
      w_nxt_idx = r_idx;
    end
  end

  // Position registers, frozen while enable is low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_x   <= {MBXY_W{1'b0}};
      r_y   <= {MBXY_W{1'b0}};
      r_idx <= {MBNUM_W{1'b0}};
    end else if (enable) begin
      r_x   <= w_nxt_x;
      r_y   <= w_nxt_y;
      r_idx <= w_nxt_idx;
    end
  end

  assign o_mb_x     = r_x;
  assign o_mb_y     = r_y;
  assign o_mbnumber = r_idx;
  assign o_nxt_x    = w_nxt_x;
  assign o_nxt_y    = w_nxt_y;
  assign o_last     = (r_idx == IDX_MAX);

endmodule

// File: rtl/mb_scheduler.sv
// Frame-level macroblock scheduler: issues raster-order descriptors to intra
// prediction one at a time, waiting for each mb_done before issuing the next.
module mb_scheduler
  import h264_pkg::*;
#(
  parameter int MB_W = MB_W_DEF,
  parameter int MB_H = MB_H_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               start,
  output logic               mb_valid,
  input  logic               mb_ready,
  input  logic               mb_done,
  output logic [MBNUM_W-1:0] mbnumber,
  output logic [MBXY_W-1:0]  mb_x,
  output logic [MBXY_W-1:0]  mb_y,
  output logic               avail_left,
  output logic               avail_top,
  output logic               avail_topleft,
  output logic               avail_topright,
  output logic               busy,
  output logic               frame_done
);

  if ((MB_W * MB_H > 2 ** MBNUM_W) || (MB_W > 2 ** MBXY_W) || (MB_H > 2 ** MBXY_W)
      || (MB_W < 1) || (MB_H < 1)) begin : g_bad_geometry
    $error("mb_scheduler: frame geometry does not fit the macroblock counters");
  end

  localparam logic [MBXY_W-1:0] X_MAX = MBXY_W'(MB_W - 1);

  sched_state_e      r_state;
  sched_state_e      w_state_nxt;
  logic              r_mb_valid;
  logic              w_valid_nxt;
  logic              r_busy;
  logic              w_busy_nxt;
  logic              r_frame_done;
  logic              w_fd_nxt;
  logic              w_clear;
  logic              w_advance;
  logic              w_last;
  logic [MBXY_W-1:0] w_nxt_x;
  logic [MBXY_W-1:0] w_nxt_y;
  mb_avail_t         r_avail;

  mb_counter2d #(
    .MB_W(MB_W),
    .MB_H(MB_H)
  ) u_counter (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .i_clear    (w_clear),
    .i_advance  (w_advance),
    .o_mb_x     (mb_x),
    .o_mb_y     (mb_y),
    .o_mbnumber (mbnumber),
    .o_nxt_x    (w_nxt_x),
    .o_nxt_y    (w_nxt_y),
    .o_last     (w_last)
  );

  // Next state and next registered outputs; mb_done advances straight into ISSUE for one-cycle reissue.
  always_comb begin
    w_state_nxt = r_state;
    w_valid_nxt = r_mb_valid;
    w_busy_nxt  = r_busy;
    w_fd_nxt    = 1'b0;
    w_clear     = 1'b0;
    w_advance   = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = ISSUE;
          w_valid_nxt = 1'b1;
          w_busy_nxt  = 1'b1;
          w_clear     = 1'b1;
        end else begin
          w_valid_nxt = 1'b0;
          w_busy_nxt  = 1'b0;
        end
      end
      ISSUE: begin
        if (r_mb_valid && mb_ready) begin
          w_state_nxt = WAIT_DONE;
          w_valid_nxt = 1'b0;
        end else begin
          w_valid_nxt = 1'b1;
        end
      end
      WAIT_DONE: begin
        if (mb_done) begin
          if (w_last) begin
            w_state_nxt = FRAME_END;
            w_busy_nxt  = 1'b0;
            w_fd_nxt    = 1'b1;
          end else begin
            w_state_nxt = ISSUE;
            w_valid_nxt = 1'b1;
            w_advance   = 1'b1;
          end
        end else begin
          w_valid_nxt = 1'b0;
        end
      end
      FRAME_END: begin
        w_state_nxt = IDLE;
        w_valid_nxt = 1'b0;
        w_busy_nxt  = 1'b0;
      end
      default: begin
        w_state_nxt = IDLE;
        w_valid_nxt = 1'b0;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // State and handshake registers; everything holds while enable is low, so mb_done is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_mb_valid   <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else if (enable) begin
      r_state      <= w_state_nxt;
      r_mb_valid   <= w_valid_nxt;
      r_busy       <= w_busy_nxt;
      r_frame_done <= w_fd_nxt;
    end
  end

  // Availability is derived from the next position so it lands together with the descriptor.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_avail <= '{1'b0, 1'b0, 1'b0, 1'b0};
    end else if (enable) begin
      r_avail <= calc_avail(w_nxt_x, w_nxt_y, X_MAX);
    end
  end

  assign mb_valid       = r_mb_valid;
  assign busy           = r_busy;
  assign frame_done     = r_frame_done;
  assign avail_left     = r_avail.left;
  assign avail_top      = r_avail.top;
  assign avail_topleft  = r_avail.topleft;
  assign avail_topright = r_avail.topright;

endmodule

// File: tb/tb_mb_scheduler.sv
// Scoreboard bench for mb_scheduler: three instances (full HD, 4x3, 2x2) driven
// through full frames, back-pressure, mid-frame reset and enable/spurious-input cases.
module tb_mb_scheduler;

  localparam int NDUT = 3;
  localparam int W_TAB [NDUT] = '{120, 4, 2};
  localparam int H_TAB [NDUT] = '{68, 3, 2};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [NDUT-1:0]       reset, enable, start, mb_ready, mb_done;
  logic [NDUT-1:0]       mb_valid, busy, frame_done;
  logic [NDUT-1:0]       avail_left, avail_top, avail_topleft, avail_topright;
  logic [NDUT-1:0][12:0] mbnumber;
  logic [NDUT-1:0][6:0]  mb_x, mb_y;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    mb_scheduler #(.MB_W(W_TAB[g]), .MB_H(H_TAB[g])) u_dut (
      .clk(clk), .reset(reset[g]), .enable(enable[g]), .start(start[g]),
      .mb_valid(mb_valid[g]), .mb_ready(mb_ready[g]), .mb_done(mb_done[g]),
      .mbnumber(mbnumber[g]), .mb_x(mb_x[g]), .mb_y(mb_y[g]),
      .avail_left(avail_left[g]), .avail_top(avail_top[g]),
      .avail_topleft(avail_topleft[g]), .avail_topright(avail_topright[g]),
      .busy(busy[g]), .frame_done(frame_done[g])
    );
  end

  int n_cmp = 0;
  int n_err = 0;
  int fd_cnt [NDUT] = '{0, 0, 0};
  int xfer_cnt [NDUT] = '{0, 0, 0};
  logic [31:0] sb_q [$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_desc(input int idx, input int w);
    int x, y;
    logic l, t;
    x = idx % w;
    y = idx / w;
    l = (x > 0);
    t = (y > 0);
    return {1'b0, 13'(idx), 7'(x), 7'(y), l, t, l & t, t & (x < w - 1)};
  endfunction

  function automatic logic [31:0] dut_desc(input int sel);
    return {1'b0, mbnumber[sel], mb_x[sel], mb_y[sel], avail_left[sel], avail_top[sel],
            avail_topleft[sel], avail_topright[sel]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Independent event counters sampled mid-cycle.
  always @(negedge clk) begin
    for (int k = 0; k < NDUT; k++) begin
      if (frame_done[k]) fd_cnt[k]++;
      if (enable[k] && mb_valid[k] && mb_ready[k]) xfer_cnt[k]++;
    end
  end

  task automatic do_frame(input int sel, input int done_dly, input int stall_idx, input int abort_idx);
    int total, fd0, xf0, wait_n;
    logic [31:0] exp;
    total = W_TAB[sel] * H_TAB[sel];
    fd0 = fd_cnt[sel];
    xf0 = xfer_cnt[sel];
    sb_q.delete();
    for (int i = 0; i < total; i++) sb_q.push_back(model_desc(i, W_TAB[sel]));
    mb_ready[sel] = 1'b1;
    start[sel] = 1'b1;
    tick();
    start[sel] = 1'b0;
    check_eq("busy_rise", 32'(busy[sel]), 32'd1);
    for (int i = 0; i < total; i++) begin
      wait_n = 0;
      while (!mb_valid[sel] && wait_n < 20) begin
        tick();
        wait_n++;
      end
      if (!mb_valid[sel]) begin
        check_eq("valid_timeout", 32'(mb_valid[sel]), 32'd1);
        return;
      end
      if (i == stall_idx) begin
        mb_ready[sel] = 1'b0;
        for (int s = 0; s < 10; s++) begin
          tick();
          check_eq("stall_valid", 32'(mb_valid[sel]), 32'd1);
          check_eq("stall_desc", dut_desc(sel), sb_q[0]);
        end
        mb_ready[sel] = 1'b1;
      end
      exp = sb_q.pop_front();
      check_eq("desc", dut_desc(sel), exp);
      check_eq("busy_mid", 32'(busy[sel]), 32'd1);
      tick();
      check_eq("wait_valid_low", 32'(mb_valid[sel]), 32'd0);
      if (i == abort_idx) begin
        reset[sel] = 1'b1;
        #1;
        check_eq("abort_valid", 32'(mb_valid[sel]), 32'd0);
        check_eq("abort_busy", 32'(busy[sel]), 32'd0);
        check_eq("abort_desc", dut_desc(sel), 32'd0);
        tick();
        reset[sel] = 1'b0;
        repeat (4) tick();
        check_eq("abort_no_valid", 32'(mb_valid[sel]), 32'd0);
        check_eq("abort_no_fd", 32'(fd_cnt[sel] - fd0), 32'd0);
        sb_q.delete();
        return;
      end
      repeat (done_dly - 1) tick();
      mb_done[sel] = 1'b1;
      tick();
      mb_done[sel] = 1'b0;
      if (i < total - 1) begin
        check_eq("reissue_latency", 32'(mb_valid[sel]), 32'd1);
      end else begin
        check_eq("frame_done", 32'(frame_done[sel]), 32'd1);
        check_eq("busy_fall", 32'(busy[sel]), 32'd0);
        check_eq("end_valid", 32'(mb_valid[sel]), 32'd0);
        tick();
        check_eq("fd_one_cycle", 32'(frame_done[sel]), 32'd0);
        check_eq("hold_last", 32'(mbnumber[sel]), 32'(total - 1));
      end
    end
    check_eq("fd_once", 32'(fd_cnt[sel] - fd0), 32'd1);
    check_eq("xfer_count", 32'(xfer_cnt[sel] - xf0), 32'(total));
    check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    reset = '1; enable = '1; start = '0; mb_ready = '0; mb_done = '0;
    tick();
    tick();
    for (int k = 0; k < NDUT; k++) begin
      check_eq("rst_valid", 32'(mb_valid[k]), 32'd0);
      check_eq("rst_busy", 32'(busy[k]), 32'd0);
      check_eq("rst_fd", 32'(frame_done[k]), 32'd0);
      check_eq("rst_desc", dut_desc(k), 32'd0);
    end
    reset = '0;
    mb_ready = '1;
    repeat (4) tick();
    for (int k = 0; k < NDUT; k++) check_eq("no_auto_start", 32'(mb_valid[k]), 32'd0);

    do_frame(1, 3, -1, -1);
    do_frame(1, 2, 5, -1);
    do_frame(1, 1, -1, 7);
    do_frame(1, 3, -1, -1);

    // Spurious mb_done in IDLE, enable-low freeze, start while busy, dropped mb_done.
    mb_ready[1] = 1'b1;
    mb_done[1] = 1'b1;
    tick();
    mb_done[1] = 1'b0;
    check_eq("idle_done_valid", 32'(mb_valid[1]), 32'd0);
    check_eq("idle_done_num", 32'(mbnumber[1]), 32'd11);
    start[1] = 1'b1;
    mb_ready[1] = 1'b0;
    tick();
    start[1] = 1'b0;
    check_eq("issue0_desc", dut_desc(1), model_desc(0, 4));
    enable[1] = 1'b0;
    for (int c = 0; c < 5; c++) begin
      mb_done[1] = 1'b1;
      start[1] = 1'b1;
      mb_ready[1] = 1'b1;
      tick();
      check_eq("en_low_valid", 32'(mb_valid[1]), 32'd1);
      check_eq("en_low_desc", dut_desc(1), model_desc(0, 4));
      check_eq("en_low_busy", 32'(busy[1]), 32'd1);
    end
    mb_done[1] = 1'b0;
    mb_ready[1] = 1'b0;
    enable[1] = 1'b1;
    tick();
    start[1] = 1'b0;
    check_eq("start_busy_desc", dut_desc(1), model_desc(0, 4));
    check_eq("start_busy_valid", 32'(mb_valid[1]), 32'd1);
    mb_ready[1] = 1'b1;
    tick();
    mb_ready[1] = 1'b0;
    check_eq("xfer_valid_low", 32'(mb_valid[1]), 32'd0);
    enable[1] = 1'b0;
    mb_done[1] = 1'b1;
    tick();
    mb_done[1] = 1'b0;
    enable[1] = 1'b1;
    repeat (3) tick();
    check_eq("done_dropped", 32'(mb_valid[1]), 32'd0);
    mb_done[1] = 1'b1;
    tick();
    mb_done[1] = 1'b0;
    check_eq("done_after_en_valid", 32'(mb_valid[1]), 32'd1);
    check_eq("done_after_en_desc", dut_desc(1), model_desc(1, 4));
    reset[1] = 1'b1;
    tick();
    reset[1] = 1'b0;
    tick();
    check_eq("cleanup_valid", 32'(mb_valid[1]), 32'd0);

    do_frame(2, 1, -1, -1);
    do_frame(0, 3, -1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule
